maxpool_window_sequencer: RTL and testbench

//  Gathers a raster-order pixel stream (one pixel/cycle) into non-overlapping STRIDE_SIZE x STRIDE_SIZE

---
 rtl/maxpool_window_sequencer.sv | 173 +++++++++++++++++
 tb/tb_maxpool_window_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_window_sequencer.sv
// Collects a raster pixel stream into non-overlapping STRIDE_SIZE x STRIDE_SIZE windows
// and hands each packed window to the Maxpool datapath over a valid/ready handshake.
module maxpool_window_sequencer #(
  parameter int unsigned STRIDE_SIZE = 2,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ROW_SIZE    = 4,
  parameter int unsigned COLUMN_SIZE = 4
) (
  input  logic                                          clock,
  input  logic                                          sreset_n,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          frame_done,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] win_data,
  output logic                                          win_valid,
  input  logic                                          win_ready
);

  localparam int unsigned S  = STRIDE_SIZE;
  localparam int unsigned NB = ROW_SIZE / S;
  localparam int unsigned NW = COLUMN_SIZE / S;
  localparam int unsigned WW = S * S * DATA_WIDTH;
  localparam int unsigned CW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  localparam int unsigned RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned KW = $clog2(S);
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(COLUMN_SIZE - 1);
  localparam logic [CW-1:0] WIN_COL_LAST = CW'(NW * S - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(ROW_SIZE - 1);
  localparam logic [KW-1:0] K_LAST       = KW'(S - 1);
  localparam logic [KW-1:0] FILL_LAST    = KW'(S - 2);
  localparam logic [BW-1:0] BAND_LAST    = BW'(NB - 1);

  typedef enum logic [2:0] {IDLE, FILL, LAST, SKIP, DRAIN} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [KW-1:0]   rib;
  logic [KW-1:0]   phase;
  logic [BW-1:0]   band;

  logic            accept;
  logic            row_end;
  logic            win_hit;
  logic            win_take;
  logic            done_set;

  logic [(S-1)*COLUMN_SIZE*DATA_WIDTH-1:0] lb;
  logic [(S-1)*DATA_WIDTH-1:0]             sr;
  logic [S*DATA_WIDTH-1:0]                 row_next;
  logic [31:0]                             col_i;
  logic [31:0]                             base_i;
  logic [WW-1:0]                           window;

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      FILL:    in_ready = 1'b1;
      LAST:    in_ready = !win_valid || win_ready;
      SKIP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign row_end  = (col == COL_LAST);
  assign win_take = win_valid && win_ready;
  assign win_hit  = (state == LAST) && accept && (phase == K_LAST) && (col <= WIN_COL_LAST);
  assign busy     = (state != IDLE);
  assign col_i    = 32'(col);

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = FILL;
      FILL: if (accept && row_end && (rib == FILL_LAST)) state_next = LAST;
      LAST: begin
        if (accept && row_end) begin
          if (band != BAND_LAST)     state_next = FILL;
          else if (row != ROW_LAST)  state_next = SKIP;
          else                       state_next = DRAIN;
        end
      end
      SKIP: if (accept && row_end && (row == ROW_LAST)) state_next = DRAIN;
      DRAIN: begin
        if (!win_valid || win_ready) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bottom row of the window is the shift register plus the pixel arriving this cycle,
  // so a window can be latched on the same edge that accepts its last pixel.
  assign row_next = {in_data, sr};

  always_comb begin
    window = '0;
    base_i = '0;
    if (col_i >= S - 1) base_i = col_i - (S - 1);
    for (int unsigned r = 0; r < S - 1; r++) begin
      for (int unsigned c = 0; c < S; c++) begin
        window[(r*S + c)*DATA_WIDTH +: DATA_WIDTH] =
          lb[(r*COLUMN_SIZE + base_i + c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    window[(S-1)*S*DATA_WIDTH +: S*DATA_WIDTH] = row_next;
  end

  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      rib        <= '0;
      phase      <= '0;
      band       <= '0;
      frame_done <= 1'b0;
      win_valid  <= 1'b0;
      win_data   <= '0;
    end else begin
      state      <= state_next;
      frame_done <= done_set;

      if ((state == IDLE) && start) begin
        col   <= '0;
        row   <= '0;
        rib   <= '0;
        phase <= '0;
        band  <= '0;
      end else if (accept) begin
        if (row_end) begin
          col   <= '0;
          phase <= '0;
          row   <= row + RW'(1);
          if (rib == K_LAST) begin
            rib  <= '0;
            band <= band + BW'(1);
          end else begin
            rib <= rib + KW'(1);
          end
        end else begin
          col   <= col + CW'(1);
          phase <= (phase == K_LAST) ? '0 : phase + KW'(1);
        end
      end

      // A fresh window may replace one being taken on this same edge.
      if (win_hit) begin
        win_data  <= window;
        win_valid <= 1'b1;
      end else if (win_take) begin
        win_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept && (state == FILL))
      lb[(32'(rib)*COLUMN_SIZE + col_i)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
    if (accept && (state == LAST))
      sr <= row_next[S*DATA_WIDTH-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Bench for maxpool_window_sequencer: 4x4 and 5x5 instances, table-driven frames,
// random pixels/gaps checked against an arithmetic window model.
module tb_maxpool_window_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned S  = 2;
  localparam int unsigned WW = S * S * DW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          sreset_n, start, in_valid, win_ready, sel;
  logic [DW-1:0] in_data;
  logic          a_busy, a_done, a_in_ready, a_win_valid;
  logic [WW-1:0] a_win_data;
  logic          b_busy, b_done, b_in_ready, b_win_valid;
  logic [WW-1:0] b_win_data;
  logic          busy, frame_done, in_ready, win_valid;
  logic [WW-1:0] win_data;

  assign busy       = sel ? b_busy      : a_busy;
  assign frame_done = sel ? b_done      : a_done;
  assign in_ready   = sel ? b_in_ready  : a_in_ready;
  assign win_valid  = sel ? b_win_valid : a_win_valid;
  assign win_data   = sel ? b_win_data  : a_win_data;

  maxpool_window_sequencer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(4), .COLUMN_SIZE(4)) dut_a (
    .clock(clock), .sreset_n(sreset_n), .start(start & ~sel), .busy(a_busy), .frame_done(a_done),
    .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .win_data(a_win_data), .win_valid(a_win_valid), .win_ready(sel ? 1'b1 : win_ready));

  maxpool_window_sequencer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(5), .COLUMN_SIZE(5)) dut_b (
    .clock(clock), .sreset_n(sreset_n), .start(start & sel), .busy(b_busy), .frame_done(b_done),
    .in_data(in_data), .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .win_data(b_win_data), .win_valid(b_win_valid), .win_ready(sel ? win_ready : 1'b1));

  typedef struct {
    bit                  sel;
    int                  ready_mode;
    int                  gap_pct;
    bit                  seq;
    bit                  mid_start;
    logic [3:0][WW-1:0]  exp_win;
  } frame_vec_t;

  localparam logic [3:0][WW-1:0] WIN4 = {64'h0010_000f_000c_000b, 64'h000e_000d_000a_0009,
                                          64'h0008_0007_0004_0003, 64'h0006_0005_0002_0001};
  localparam logic [3:0][WW-1:0] WIN5 = {64'h0013_0012_000e_000d, 64'h0011_0010_000c_000b,
                                          64'h0009_0008_0004_0003, 64'h0007_0006_0002_0001};

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] pix [25];
  logic [WW-1:0] got_q [$];
  logic [WW-1:0] exp_q [$];
  int            done_cnt, acc_cnt, pidx, busy_low, rows, cols, ready_mode;
  bit            exp_next, prev_pend, stalled;
  logic [WW-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Expected windows straight from the raster layout: band b, window w, element (r,c).
  task automatic model(input int nr, input int nc);
    exp_q.delete();
    for (int b = 0; b < nr / S; b++)
      for (int w = 0; w < nc / S; w++) begin
        logic [WW-1:0] wv = '0;
        for (int r = 0; r < S; r++)
          for (int c = 0; c < S; c++)
            wv[(r*S + c)*DW +: DW] = pix[(b*S + r)*nc + w*S + c];
        exp_q.push_back(wv);
      end
  endtask

  always @(negedge clock) begin : mon
    int pr, pc;
    if (!sreset_n) begin
      exp_next  = 1'b0;
      prev_pend = 1'b0;
    end else begin
      if (exp_next) check("win_latency", 64'(win_valid), 64'd1);
      if (prev_pend) begin
        check("win_hold_valid", 64'(win_valid), 64'd1);
        check("win_hold_data", win_data, prev_data);
      end
      if (win_valid && win_ready) got_q.push_back(win_data);
      if (frame_done) done_cnt++;
      exp_next = 1'b0;
      if (in_valid && in_ready) begin
        pr = pidx / cols;
        pc = pidx % cols;
        exp_next = (pr % S == S - 1) && (pr < (rows / S) * S) &&
                   (pc % S == S - 1) && (pc < (cols / S) * S);
        pidx++;
        acc_cnt++;
      end
      prev_pend = win_valid && !win_ready;
      prev_data = win_data;
    end
  end

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (ready_mode == 1 && !stalled && win_valid) begin
        stalled   = 1'b1;
        win_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_win_valid", 64'(win_valid), 64'd1);
          @(posedge clock); #1;
        end
        win_ready = 1'b1;
      end
    end
  end

  task automatic send_pixel(input logic [DW-1:0] v, input int gap_pct, input bit pulse_start);
    int t = 0;
    for (int g = 0; g < 8 && $urandom_range(99, 0) < gap_pct; g++) begin
      in_valid = 1'b0;
      @(posedge clock); #1;
    end
    in_data  = v;
    in_valid = 1'b1;
    start    = pulse_start;
    @(negedge clock);
    if (!busy) busy_low++;
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic begin_frame(input bit s);
    sel  = s;
    rows = s ? 5 : 4;
    cols = s ? 5 : 4;
    got_q.delete();
    done_cnt = 0; acc_cnt = 0; pidx = 0; busy_low = 0; stalled = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v, input int id);
    int n, t;
    ready_mode = v.ready_mode;
    n = (v.sel ? 5 : 4) * (v.sel ? 5 : 4);
    for (int i = 0; i < n; i++) pix[i] = v.seq ? DW'(i + 1) : DW'($urandom);
    if (v.seq) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(v.exp_win[i]);
    end else begin
      model(v.sel ? 5 : 4, v.sel ? 5 : 4);
    end
    begin_frame(v.sel);
    for (int i = 0; i < n; i++) send_pixel(pix[i], v.gap_pct, v.mid_start && i == 5);
    t = 0;
    while (done_cnt == 0 && t < 100) begin
      @(posedge clock);
      t++;
    end
    repeat (5) @(posedge clock);
    #1;
    check($sformatf("f%0d_frame_done_count", id), 64'(done_cnt), 64'd1);
    check($sformatf("f%0d_pixels_accepted", id), 64'(acc_cnt), 64'(n));
    check($sformatf("f%0d_busy_during_frame", id), 64'(busy_low), 64'd0);
    check($sformatf("f%0d_busy_after", id), 64'(busy), 64'd0);
    check($sformatf("f%0d_window_count", id), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("f%0d_window%0d", id, i), got_q[i], exp_q[i]);
    ready_mode = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_win_valid"}, 64'(win_valid), 64'd0);
    check({tag, "_win_data"}, win_data, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t vecs[7];
    vecs[0] = '{sel: 1'b0, ready_mode: 0, gap_pct: 0,  seq: 1'b1, mid_start: 1'b0, exp_win: WIN4};
    vecs[1] = '{sel: 1'b0, ready_mode: 1, gap_pct: 0,  seq: 1'b1, mid_start: 1'b0, exp_win: WIN4};
    vecs[2] = '{sel: 1'b1, ready_mode: 0, gap_pct: 0,  seq: 1'b1, mid_start: 1'b0, exp_win: WIN5};
    vecs[3] = '{sel: 1'b0, ready_mode: 0, gap_pct: 50, seq: 1'b1, mid_start: 1'b0, exp_win: WIN4};
    vecs[4] = '{sel: 1'b0, ready_mode: 0, gap_pct: 30, seq: 1'b0, mid_start: 1'b0, exp_win: '0};
    vecs[5] = '{sel: 1'b1, ready_mode: 1, gap_pct: 40, seq: 1'b0, mid_start: 1'b0, exp_win: '0};
    vecs[6] = '{sel: 1'b1, ready_mode: 0, gap_pct: 0,  seq: 1'b0, mid_start: 1'b0, exp_win: '0};

    sreset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    ready_mode = 0; rows = 4; cols = 4;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset_a");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset_b");
    sel = 1'b0;
    @(posedge clock); #1;
    sreset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

    // in_valid while IDLE must be ignored, then a frame with start re-pulsed mid-frame
    in_valid = 1'b1;
    in_data  = 16'd99;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    run_frame('{sel: 1'b0, ready_mode: 0, gap_pct: 0, seq: 1'b1, mid_start: 1'b1, exp_win: WIN4}, 7);

    // reset in the middle of a frame, then a clean frame reproduces the basic result
    begin_frame(1'b0);
    for (int i = 0; i < 7; i++) send_pixel(DW'(i + 1), 0, 1'b0);
    sreset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("midreset");
    @(posedge clock); #1;
    sreset_n = 1'b1;
    run_frame(vecs[0], 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
